// File: rtl/turbo_rsc_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turbo_enc_pkg
// Description : Shared constants, generator taps and FSM state type for the
//               dual RSC turbo encoder stage.
// Revision    : 1.0  initial release
// ============================================================================
package turbo_enc_pkg;

   localparam int K_DEFAULT     = 4096;
   localparam int CNT_W_DEFAULT = 12;

   // Bit k of a generator selects state bit s[2-k]: bit0 = D^3, bit1 = D^2, bit2 = D.
   localparam logic [2:0] G_FB = 3'b011;   // feedback taps D^2, D^3
   localparam logic [2:0] G_FF = 3'b101;   // feedforward taps D, D^3

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      TAIL1 = 2'd2,
      TAIL2 = 2'd3
   } enc_state_t;

   // XOR of the state bits selected by a generator tap mask.
   function automatic logic tap_xor(input logic [2:0] taps, input logic [2:0] s);
      return ^(taps & {s[0], s[1], s[2]});
   endfunction

endpackage
`default_nettype wire

// File: rtl/turbo_rsc_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : turbo_rsc_encoder_if
// Description : Bit-stream bus between the interleaver buffer, the dual RSC
//               encoder stage and its downstream consumer.
// Revision    : 1.0  initial release
// ============================================================================
interface turbo_rsc_encoder_if;

   logic bin_in;
   logic bin_int_in;
   logic valid_in;
   logic sys_out;
   logic par1_out;
   logic par2_out;
   logic valid_out;
   logic tail_out;
   logic blk_done;
   logic ovf_err;

   // Upstream/environment view: drives bits, observes encoded streams.
   modport master (
      output bin_in, bin_int_in, valid_in,
      input  sys_out, par1_out, par2_out, valid_out, tail_out, blk_done, ovf_err
   );

   // Encoder view.
   modport slave (
      input  bin_in, bin_int_in, valid_in,
      output sys_out, par1_out, par2_out, valid_out, tail_out, blk_done, ovf_err
   );

endinterface
`default_nettype wire

// File: rtl/turbo_rsc_encoder_rsc.sv
`default_nettype none
// ============================================================================
// Module      : rsc_encoder
// Description : One recursive systematic convolutional encoder,
//               g0 = 1+D^2+D^3 (feedback), g1 = 1+D+D^3 (feedforward).
//               Parity and tail bit are combinational; the caller registers.
// Revision    : 1.0  initial release
// ============================================================================
module rsc_encoder
   import turbo_enc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic step,      // advance the trellis this cycle
   input  logic term,      // termination: feed the feedback bit back as input
   input  logic u,         // information bit
   output logic parity,
   output logic tail_sys   // feedback bit, the systematic bit during termination
);

   logic [2:0] r_state;    // r_state[0] is the newest bit
   logic       w_fb;
   logic       w_u_eff;
   logic       w_a;

   // Trellis equations; with term set the input equals fb so the new bit is 0.
   always_comb begin
      w_fb     = tap_xor(G_FB, r_state);
      w_u_eff  = term ? w_fb : u;
      w_a      = w_u_eff ^ w_fb;
      parity   = w_a ^ tap_xor(G_FF, r_state);
      tail_sys = w_fb;
   end

   // Shift register advances only on a step; otherwise it holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= 3'b000;
      end else if (step) begin
         r_state <= {r_state[1:0], w_a};
      end
   end

endmodule
`default_nettype wire

// File: rtl/turbo_rsc_encoder.sv
`default_nettype none
// ============================================================================
// Module      : turbo_rsc_encoder
// Description : Dual RSC encoder stage. Encodes a K-bit block on both the
//               natural and interleaved streams, then terminates encoder 1
//               (TAIL1) and encoder 2 (TAIL2) with three tail steps each.
// Revision    : 1.0  initial release
// ============================================================================
module turbo_rsc_encoder
   import turbo_enc_pkg::*;
#(
   parameter int K     = K_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
)(
   input  logic                 clk,
   input  logic                 reset,
   turbo_rsc_encoder_if.slave   bus
);

   generate
      if ((2 ** CNT_W) < K) begin : g_cnt_w_check
         $error("turbo_rsc_encoder: CNT_W is too narrow to count K bits");
      end
   endgenerate

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(K - 1);

   enc_state_t       r_state;
   enc_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       r_tcnt;
   logic [1:0]       w_tcnt_nxt;

   logic w_step1, w_step2, w_term1, w_term2;
   logic w_par1, w_par2, w_tsys1, w_tsys2;
   logic w_sys, w_p1, w_p2, w_vld, w_tail, w_done, w_ovf;

   logic r_sys, r_p1, r_p2, r_vld, r_tail, r_done, r_ovf;

   rsc_encoder u_enc1 (
      .clk      (clk),
      .reset    (reset),
      .step     (w_step1),
      .term     (w_term1),
      .u        (bus.bin_in),
      .parity   (w_par1),
      .tail_sys (w_tsys1)
   );

   rsc_encoder u_enc2 (
      .clk      (clk),
      .reset    (reset),
      .step     (w_step2),
      .term     (w_term2),
      .u        (bus.bin_int_in),
      .parity   (w_par2),
      .tail_sys (w_tsys2)
   );

   // State, bit counter and tail-step counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_tcnt  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tcnt  <= w_tcnt_nxt;
      end
   end

   // Next-state, encoder stepping and output selection.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tcnt_nxt  = r_tcnt;
      w_step1     = 1'b0;
      w_step2     = 1'b0;
      w_term1     = 1'b0;
      w_term2     = 1'b0;
      w_sys       = 1'b0;
      w_p1        = 1'b0;
      w_p2        = 1'b0;
      w_vld       = 1'b0;
      w_tail      = 1'b0;
      w_done      = 1'b0;
      w_ovf       = 1'b0;

      case (r_state)
         IDLE, DATA: begin
            if (bus.valid_in) begin
               w_step1 = 1'b1;
               w_step2 = 1'b1;
               w_sys   = bus.bin_in;
               w_p1    = w_par1;
               w_p2    = w_par2;
               w_vld   = 1'b1;
               if (r_cnt == C_LAST) begin
                  // Last information bit: counter returns to 0 for the next block.
                  w_cnt_nxt   = '0;
                  w_tcnt_nxt  = 2'd0;
                  w_state_nxt = TAIL1;
               end else begin
                  w_cnt_nxt   = r_cnt + 1'b1;
                  w_state_nxt = DATA;
               end
            end
         end
         TAIL1: begin
            w_ovf   = bus.valid_in;
            w_step1 = 1'b1;
            w_term1 = 1'b1;
            w_sys   = w_tsys1;
            w_p1    = w_par1;
            w_vld   = 1'b1;
            w_tail  = 1'b1;
            if (r_tcnt == 2'd2) begin
               w_tcnt_nxt  = 2'd0;
               w_state_nxt = TAIL2;
            end else begin
               w_tcnt_nxt  = r_tcnt + 2'd1;
            end
         end
         TAIL2: begin
            w_ovf   = bus.valid_in;
            w_step2 = 1'b1;
            w_term2 = 1'b1;
            w_sys   = w_tsys2;
            w_p2    = w_par2;
            w_vld   = 1'b1;
            w_tail  = 1'b1;
            if (r_tcnt == 2'd2) begin
               w_done      = 1'b1;
               w_tcnt_nxt  = 2'd0;
               w_state_nxt = IDLE;
            end else begin
               w_tcnt_nxt  = r_tcnt + 2'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Registered outputs; ovf_err is sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sys  <= 1'b0;
         r_p1   <= 1'b0;
         r_p2   <= 1'b0;
         r_vld  <= 1'b0;
         r_tail <= 1'b0;
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_sys  <= w_sys;
         r_p1   <= w_p1;
         r_p2   <= w_p2;
         r_vld  <= w_vld;
         r_tail <= w_tail;
         r_done <= w_done;
         r_ovf  <= r_ovf | w_ovf;
      end
   end

   assign bus.sys_out   = r_sys;
   assign bus.par1_out  = r_p1;
   assign bus.par2_out  = r_p2;
   assign bus.valid_out = r_vld;
   assign bus.tail_out  = r_tail;
   assign bus.blk_done  = r_done;
   assign bus.ovf_err   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_turbo_rsc_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_turbo_rsc_encoder
// Description : Self-checking bench for the dual RSC encoder stage. A K=8
//               instance covers impulse vectors, gaps, overflow and reset;
//               a K=4096 instance covers back-to-back full-size blocks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_turbo_rsc_encoder;

   typedef struct packed {
      logic sys;
      logic p1;
      logic p2;
      logic tail;
      logic done;
   } out_rec_t;

   typedef struct {
      bit       v;
      bit       b1;
      bit       b2;
      out_rec_t exp;
   } vec_t;

   logic clk;
   logic reset;
   logic bin_in, bin_int_in, valid_in;

   int checks = 0;
   int errors = 0;

   out_rec_t mon8_q[$];
   out_rec_t mon4_q[$];
   out_rec_t exp_q[$];
   int       done8_cnt = 0;
   int       done4_cnt = 0;

   bit mu1[4096];
   bit mu2[4096];
   bit h1[4104];
   bit h2[4104];

   vec_t tbl[28];

   turbo_rsc_encoder_if if8 ();
   turbo_rsc_encoder_if if4 ();

   assign if8.bin_in     = bin_in;
   assign if8.bin_int_in = bin_int_in;
   assign if8.valid_in   = valid_in;
   assign if4.bin_in     = bin_in;
   assign if4.bin_int_in = bin_int_in;
   assign if4.valid_in   = valid_in;

   turbo_rsc_encoder #(.K(8), .CNT_W(3)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (if8.slave)
   );

   turbo_rsc_encoder #(.K(4096), .CNT_W(12)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (if4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every qualified output word on the falling edge.
   always @(negedge clk) begin
      if (if8.valid_out === 1'b1)
         mon8_q.push_back({if8.sys_out, if8.par1_out, if8.par2_out, if8.tail_out, if8.blk_done});
      if (if4.valid_out === 1'b1)
         mon4_q.push_back({if4.sys_out, if4.par1_out, if4.par2_out, if4.tail_out, if4.blk_done});
      if (if8.blk_done === 1'b1) done8_cnt++;
      if (if4.blk_done === 1'b1) done4_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // Inputs change just after a rising edge and are sampled on the next one.
   task automatic drive(input bit v, input bit b1, input bit b2);
      valid_in   = v;
      bin_in     = b1;
      bin_int_in = b2;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         mu1[i] = 1'($urandom_range(0, 1));
         mu2[i] = 1'($urandom_range(0, 1));
      end
   endtask

   // Reference: a[n] = u[n] ^ a[n-2] ^ a[n-3] (division by 1+D^2+D^3),
   // p[n] = a[n] ^ a[n-1] ^ a[n-3] (multiplication by 1+D+D^3).
   // h[i+3] holds a[i]; h[0..2] are the zero initial conditions.
   // Termination picks u so that the new a is 0, emitting that u as sys.
   task automatic model_block(input int n);
      bit a, p1, p2, fb, tp;
      for (int i = 0; i < 4104; i++) begin
         h1[i] = 1'b0;
         h2[i] = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         a = mu1[i] ^ h1[i+1] ^ h1[i];
         h1[i+3] = a;
         p1 = a ^ h1[i+2] ^ h1[i];
         a = mu2[i] ^ h2[i+1] ^ h2[i];
         h2[i+3] = a;
         p2 = a ^ h2[i+2] ^ h2[i];
         exp_q.push_back({mu1[i], p1, p2, 1'b0, 1'b0});
      end
      for (int t = 0; t < 3; t++) begin
         fb = h1[n+t+1] ^ h1[n+t];
         h1[n+t+3] = 1'b0;
         tp = h1[n+t+2] ^ h1[n+t];
         exp_q.push_back({fb, tp, 1'b0, 1'b1, 1'b0});
      end
      for (int t = 0; t < 3; t++) begin
         fb = h2[n+t+1] ^ h2[n+t];
         h2[n+t+3] = 1'b0;
         tp = h2[n+t+2] ^ h2[n+t];
         exp_q.push_back({fb, 1'b0, tp, 1'b1, (t == 2)});
      end
   endtask

   task automatic compare_stream(input string name, input bit big);
      out_rec_t got, want;
      int idx;
      int ngot;
      idx  = 0;
      ngot = big ? mon4_q.size() : mon8_q.size();
      check({name, " valid_out count"}, ngot, exp_q.size());
      while (exp_q.size() != 0) begin
         want = exp_q.pop_front();
         if ((big ? mon4_q.size() : mon8_q.size()) == 0) got = 'x;
         else if (big) got = mon4_q.pop_front();
         else got = mon8_q.pop_front();
         check($sformatf("%s word %0d {sys,p1,p2,tail,done}", name, idx), got, want);
         idx++;
      end
      if (big) mon4_q.delete();
      else mon8_q.delete();
   endtask

   task automatic drive_block(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, mu1[i], mu2[i]);
   endtask

   initial begin
      logic [7:0] imp_par;
      logic [2:0] tsys;
      logic [2:0] tpar;
      int         i8;
      int         saved_done;

      imp_par = 8'b0100_1111;   // 1,1,1,1,0,0,1,0 from bit 0 upward
      tsys    = 3'b110;         // tail sys 0,1,1
      tpar    = 3'b101;         // tail parity 1,0,1

      // Impulse vectors: set 0 on the natural stream, set 1 on the interleaved stream.
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < 14; i++) begin
            i8 = t * 14 + i;
            tbl[i8].v  = (i < 8);
            tbl[i8].b1 = (t == 0) && (i == 0);
            tbl[i8].b2 = (t == 1) && (i == 0);
            if (i < 8)
               tbl[i8].exp = {tbl[i8].b1, (t == 0) & imp_par[i], (t == 1) & imp_par[i], 1'b0, 1'b0};
            else if (i < 11)
               tbl[i8].exp = {(t == 0) & tsys[i-8], (t == 0) & tpar[i-8], 1'b0, 1'b1, 1'b0};
            else
               tbl[i8].exp = {(t == 1) & tsys[i-11], 1'b0, (t == 1) & tpar[i-11], 1'b1, (i == 13)};
         end
      end

      // Reset state.
      reset = 1'b1;
      valid_in = 1'b0;
      bin_in = 1'b0;
      bin_int_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset valid_out", if8.valid_out, 1'b0);
      check("reset sys_out", if8.sys_out, 1'b0);
      check("reset par1_out", if8.par1_out, 1'b0);
      check("reset par2_out", if8.par2_out, 1'b0);
      check("reset tail_out", if8.tail_out, 1'b0);
      check("reset blk_done", if8.blk_done, 1'b0);
      check("reset ovf_err", if8.ovf_err, 1'b0);
      reset = 1'b0;
      idle(2);

      // Impulse tables.
      for (int t = 0; t < 2; t++) begin
         mon8_q.delete();
         for (int i = 0; i < 14; i++) drive(tbl[t*14+i].v, tbl[t*14+i].b1, tbl[t*14+i].b2);
         idle(2);
         check($sformatf("impulse %0d valid_out count", t), mon8_q.size(), 14);
         for (int i = 0; i < 14; i++) begin
            if (i < mon8_q.size())
               check($sformatf("impulse %0d word %0d {sys,p1,p2,tail,done}", t, i),
                     mon8_q[i], tbl[t*14+i].exp);
         end
         mon8_q.delete();
      end

      // Random block with input gaps.
      fill_random(8);
      model_block(8);
      for (int i = 0; i < 8; i++) begin
         while ($urandom_range(0, 2) == 0) drive(1'b0, 1'b1, 1'b1);
         drive(1'b1, mu1[i], mu2[i]);
      end
      idle(8);
      compare_stream("gapped block", 1'b0);
      check("gapped enc1 state", dut8.u_enc1.r_state, 3'b000);
      check("gapped enc2 state", dut8.u_enc2.r_state, 3'b000);
      check("gapped counter", dut8.r_cnt, 0);
      check("ovf_err before overflow", if8.ovf_err, 1'b0);

      // Input asserted during the 2nd TAIL1 cycle.
      fill_random(8);
      model_block(8);
      drive_block(8);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      idle(6);
      compare_stream("overflow block", 1'b0);
      check("ovf_err set", if8.ovf_err, 1'b1);
      fill_random(8);
      model_block(8);
      drive_block(8);
      idle(8);
      compare_stream("block after overflow", 1'b0);
      check("ovf_err sticky", if8.ovf_err, 1'b1);

      // Reset asserted as input bit 5 is presented.
      fill_random(8);
      drive_block(5);
      saved_done = done8_cnt;
      valid_in   = 1'b1;
      bin_in     = mu1[5];
      bin_int_in = mu2[5];
      reset      = 1'b1;
      #1;
      check("mid reset valid_out", if8.valid_out, 1'b0);
      check("mid reset sys_out", if8.sys_out, 1'b0);
      check("mid reset par1_out", if8.par1_out, 1'b0);
      check("mid reset par2_out", if8.par2_out, 1'b0);
      check("mid reset tail_out", if8.tail_out, 1'b0);
      check("mid reset ovf_err", if8.ovf_err, 1'b0);
      @(posedge clk);
      #1;
      idle(3);
      reset = 1'b0;
      idle(10);
      check("mid reset no blk_done", done8_cnt, saved_done);
      mon8_q.delete();
      fill_random(8);
      model_block(8);
      drive_block(8);
      idle(8);
      compare_stream("block after reset", 1'b0);

      // Two back-to-back K=4096 blocks.
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(2);
      mon4_q.delete();
      done4_cnt = 0;
      fill_random(4096);
      model_block(4096);
      drive_block(4096);
      idle(6);
      check("b2b blk_done before second block", if4.blk_done, 1'b1);
      fill_random(4096);
      model_block(4096);
      drive_block(4096);
      idle(9);
      check("b2b blk_done pulses", done4_cnt, 2);
      compare_stream("back-to-back 4096", 1'b1);
      check("b2b enc1 state", dut4.u_enc1.r_state, 3'b000);
      check("b2b enc2 state", dut4.u_enc2.r_state, 3'b000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
